// File: rtl/stop_watch_lap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stop_watch_lap: debounced start/stop + lap/clear stopwatch, BCD display   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module stop_watch_lap #(
  parameter int CLK_FREQ_HZ     = 100000000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MODE            = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  btn,
  output logic [15:0] value,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  localparam int c_pre_div = CLK_FREQ_HZ / 100;
  localparam int c_pre_w   = (c_pre_div > 1) ? $clog2(c_pre_div) : 1;
  localparam int c_deb_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(c_pre_div - 1);
  localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);
  localparam logic [c_deb_w-1:0] c_deb_max = c_deb_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_deb_w-1:0] c_deb_one = c_deb_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic               w_deb_tick;
  logic [1:0]         w_press;
  logic               w_start;
  logic               w_lap;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_latch;
  logic               w_clear;
  logic               w_count;
  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;
  logic [3:0]         r_cs1, r_cs10, r_s1, r_s10, r_m1, r_m10;
  logic               w_cy_cs10, w_cy_s1, w_cy_s10, w_cy_m1, w_cy_m10, w_wrap;
  logic [15:0]        w_live;
  logic [15:0]        r_hold;
  logic [15:0]        r_value;
  logic               r_running;
  logic               r_lap_active;
  logic               r_wrap;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_deb_tick = (r_deb_cnt == c_deb_max);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)        r_deb_cnt <= '0;
    else if (w_deb_tick) r_deb_cnt <= '0;
    else                 r_deb_cnt <= r_deb_cnt + c_deb_one;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0] r_sync;
    logic       r_smp;
    logic       r_lvl;
    logic       r_lvl_d;

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_sync  <= 2'b00;
        r_smp   <= 1'b0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], btn[gi]};
        r_lvl_d <= r_lvl;
        if (w_deb_tick) begin
          r_smp <= r_sync[1];
          if (r_sync[1] == r_smp) r_lvl <= r_sync[1];
        end
      end
    end

    assign w_press[gi] = r_lvl & ~r_lvl_d;
  end

  // Start has priority; a lap press in the same cycle is dropped.
  assign w_start = w_press[0];
  assign w_lap   = w_press[1] & ~w_press[0];

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_start) w_state_nxt = S_STOP;
        else if (w_lap) begin
          w_state_nxt = S_LAP;
          w_latch     = 1'b1;
        end
      end
      S_LAP: begin
        if (w_start)    w_state_nxt = S_STOP;
        else if (w_lap) w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (w_start) w_state_nxt = S_RUN;
        else if (w_lap) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_count = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick  = w_count && (r_pre == c_pre_max);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)     r_pre <= '0;
    else if (w_clear) r_pre <= '0;
    else if (w_tick)  r_pre <= '0;
    else if (w_count) r_pre <= r_pre + c_pre_one;
  end

  function automatic logic [3:0] f_nxt(input logic [3:0] d, input logic [3:0] lim,
                                       input logic inc, input logic clr);
    if (clr)      return 4'd0;
    else if (inc) return (d == lim) ? 4'd0 : d + 4'd1;
    else          return d;
  endfunction

  assign w_cy_cs10 = w_tick    && (r_cs1  == 4'd9);
  assign w_cy_s1   = w_cy_cs10 && (r_cs10 == 4'd9);
  assign w_cy_s10  = w_cy_s1   && (r_s1   == 4'd9);
  assign w_cy_m1   = w_cy_s10  && (r_s10  == 4'd5);
  assign w_cy_m10  = w_cy_m1   && (r_m1   == 4'd9);
  assign w_wrap    = w_cy_m10  && (r_m10  == 4'd5);

  // Digits are rewritten every cycle (hold is an explicit self-assignment).
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cs1  <= 4'd0;
      r_cs10 <= 4'd0;
      r_s1   <= 4'd0;
      r_s10  <= 4'd0;
      r_m1   <= 4'd0;
      r_m10  <= 4'd0;
      r_wrap <= 1'b0;
    end else begin
      r_cs1  <= f_nxt(r_cs1,  4'd9, w_tick,    w_clear);
      r_cs10 <= f_nxt(r_cs10, 4'd9, w_cy_cs10, w_clear);
      r_s1   <= f_nxt(r_s1,   4'd9, w_cy_s1,   w_clear);
      r_s10  <= f_nxt(r_s10,  4'd5, w_cy_s10,  w_clear);
      r_m1   <= f_nxt(r_m1,   4'd9, w_cy_m1,   w_clear);
      r_m10  <= f_nxt(r_m10,  4'd5, w_cy_m10,  w_clear);
      r_wrap <= w_wrap;
    end
  end

  assign w_live = (MODE == 1) ? {r_m10, r_m1, r_s10, r_s1} : {r_s10, r_s1, r_cs10, r_cs1};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hold       <= 16'h0000;
      r_value      <= 16'h0000;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      if (w_clear)      r_hold <= 16'h0000;
      else if (w_latch) r_hold <= w_live;
      r_value      <= (r_state == S_LAP) ? r_hold : w_live;
      r_running    <= w_count;
      r_lap_active <= (r_state == S_LAP);
    end
  end

  assign value      = r_value;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: doc/stop_watch_lap.md
Name: stop_watch_lap

Overview:
- Parametrised stopwatch core: debounced start/stop and lap/clear buttons, centisecond/second/minute BCD timebase, lap freeze, selectable display mode.
- Outputs a 16-bit BCD display word (4 digits) that feeds the existing 4-digit FND controller unchanged.
- Successor to the seconds-only stopwatch; adds lap hold, clear, pause/resume, minutes and a mode select.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency; one centisecond tick every CLK_FREQ_HZ/100 cycles (integer division).
- DEBOUNCE_CYCLES, 100000, clock cycles between button samples.
- MODE, 0, display format: 0 = SS.CC (seconds.centiseconds), 1 = MM.SS (minutes.seconds).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn  input  2  raw buttons, active high: btn[0] = start/stop, btn[1] = lap/clear
- value  output  16  BCD display word {d3,d2,d1,d0}, d0 least significant
- running  output  1  high while in RUN or LAP
- lap_active  output  1  high while in LAP (display frozen)
- wrap  output  1  one-cycle pulse on 59:59.99 -> 00:00.00 rollover

Behaviour:
- Reset: asynchronous on reset_n low, released synchronously to clk.
  - Reset values: value = 16'h0000, running = 0, lap_active = 0, wrap = 0, all counters 0, state IDLE, debounced levels 0.
- Debounce, per button:
  - Sample divider counts 0..DEBOUNCE_CYCLES-1.
  - On terminal count, sample the raw input.
  - The debounced level updates only when two consecutive samples agree.
  - Press pulse: one clk cycle, asserted the cycle after the debounced level goes 0 -> 1.
  - Release produces no event.
- Timebase:
  - Prescaler counts 0..CLK_FREQ_HZ/100-1 only in RUN and LAP; it holds in STOP and is zeroed on clear.
  - Terminal count issues a cs_tick.
  - cs (BCD 00-99), sec (00-59) and min (00-59) increment with ripple carry in the same cycle as cs_tick.
  - 59:59.99 + tick -> 00:00.00, wrap asserted that cycle, counting continues.
- States:
  - IDLE: counters zero.
    - start -> RUN.
    - lap ignored.
  - RUN: counting, live display.
    - start -> STOP.
    - lap -> LAP (latch the current display into the hold register).
  - LAP: counting continues, value shows the hold register.
    - lap -> RUN (live display again).
    - start -> STOP.
    - lap_active clears on leaving LAP.
  - STOP: counting halted, live display of the held count.
    - start -> RUN (resume from the held count and prescaler phase).
    - lap -> IDLE (clear all counters, prescaler and hold register).
- Simultaneous start and lap pulses in one cycle: start wins, lap is discarded.
- value:
  - MODE 0 = {sec10, sec1, cs10, cs1}.
  - MODE 1 = {min10, min1, sec10, sec1}.
  - Registered: updates the cycle after the counter change.
  - In LAP it holds the latched word.
- running and lap_active are registered from state and take their new value the cycle after the transition.
- Reset mid-count or mid-LAP: immediate return to reset values, with no wrap pulse.
- BCD arithmetic:
  - Each digit is 4 bits and never exceeds 9.
  - The tens of sec/min never exceed 5.
  - No binary-to-BCD conversion.

Test Plan:
- Bench parameters CLK_FREQ_HZ=10000 (100 clk per cs), DEBOUNCE_CYCLES=4, MODE=0.
  - Reset, then press btn[0] cleanly for 20 cycles -> running=1.
  - After 150*100 cycles, value=16'h0150 (01.50) within ±1 cs of debounce latency.
- Bounce: toggle btn[0] every 2 cycles for 30 cycles, then hold high -> exactly one start pulse, running=1 and no spurious stop.
- Lap, while running:
  - At value=16'h0230, press btn[1] -> lap_active=1 and value frozen at 16'h0230 while counting continues.
  - Press btn[1] again after 100 cs -> value ≈16'h0330 live, lap_active=0.
- Stop and clear:
  - Press btn[0] -> running=0 and value constant for 1000 cycles.
  - Press btn[0] -> resumes from the same value.
  - Press btn[0], then btn[1] -> value=16'h0000 and IDLE; a further btn[1] in IDLE has no effect.
- MODE=1:
  - Run to 59:59.99 -> value=16'h5959.
  - Next tick -> value=16'h0000 and wrap high for exactly 1 cycle.
- Simultaneous btn[0] and btn[1] press in RUN -> state STOP with lap_active=0.
- Assert reset_n low mid-LAP -> all outputs 0 asynchronously.
